seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Radix-2 shift-and-add unsigned multiplier, N x N -> 2N bits, computed over multiple cycles.
- Sits directly downstream of one ripple_carry_adder instance and consumes its sum and carry-out every iteration.
- Uses valid/ready handshakes on both input and output, so it can be dropped into integer datapaths.

Parameters:
- N, default 32: operand width in bits. Must be 2 or more. The product width is 2N.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  operands x and y are valid
- in_ready  output  1  block can accept operands
- x  input  N  multiplicand, unsigned
- y  input  N  multiplier, unsigned
- out_valid  output  1  product p is valid
- out_ready  input  1  downstream accepts p
- p  output  2N  product x*y

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, p=0, and all internal registers are 0. Reset asserted in any state, including mid-BUSY, aborts the operation immediately. No output is produced for the aborted operation.
- Registers:
  - mcand (N bits)
  - hi (N bits)
  - lo (N bits)
  - cnt (ceil(log2(N+1)) bits)
  - state
- Adder hookup: one ripple_carry_adder with x=hi, y=(lo[0] ? mcand : 0), cin=0, giving sum and cout.
- FSM:
  - IDLE: in_ready=1. When in_valid=1 on a clock edge (the capture edge E0): mcand<=x, hi<=0, lo<=y, cnt<=0, go to BUSY. Inputs are not sampled in any other state.
  - BUSY: in_ready=0. On each edge, {hi,lo} <= {cout, sum, lo[N-1:1]} and cnt<=cnt+1. On the edge where cnt==N-1, go to DONE.
  - DONE: out_valid=1 and p={hi,lo}. p stays stable while out_ready=0. On an edge with out_ready=1, go to IDLE and out_valid drops.
- Latency: out_valid is high after edge E0+N, i.e. N cycles after capture. Minimum initiation interval is N+2 cycles.
- in_ready is combinational from state only (state==IDLE). There is no combinational path from in_valid or out_ready to any output.
- Arithmetic: carry-out of each partial add is always captured in the shift, so the result never overflows. x=y=2^N-1 gives 2^(2N)-2^(N+1)+1.
- p equals {hi,lo} in DONE and holds its last value in IDLE and BUSY. Consumers sample p only with out_valid.

Optional Feature:
- Macro: SEQ_MULTIPLIER_EARLY_EXIT_EN.
- Defined: in BUSY, if the unprocessed multiplier bits (lo[N-1-cnt:0]) are all zero, the next edge loads {hi,lo} <= {hi,lo} >> (N-cnt) and goes to DONE. This finishing step replaces the remaining iterations.
- Resulting latency, where k is the index of y's most significant set bit:
  - y=0: 1 cycle.
  - k<N-1: k+2 cycles.
  - k=N-1: N cycles.
- The product is identical to the non-early-exit result in every case.
- Undefined: fixed latency of N cycles for every operand pair.

Test Plan:
- N=8, x=3, y=5, out_ready=1 -> out_valid after exactly 8 cycles with p=15. Back in IDLE (in_ready=1) the next cycle.
- N=8, x=255, y=255 -> p=0xFE01, with the carry-out of every iteration preserved.
- N=8, x=200, y=0, out_ready held low for 5 cycles -> p=0 held stable with out_valid=1 and in_ready=0 throughout. Returns to IDLE on the first out_ready=1 edge.
- N=8, assert rst for 1 cycle during the 4th BUSY cycle of a 7x9 operation -> all outputs at reset values. A new 6x7 request afterwards returns p=42 with no residue from the aborted operation.
- N=8, in_valid held high with random operands in a back-to-back stream of 100 pairs -> every p matches the golden x*y, one result per N+2 cycles, and no operands are taken while in_ready=0.
- With SEQ_MULTIPLIER_EARLY_EXIT_EN, N=8, x=9: y=0 -> p=0 after 1 cycle; y=1 -> p=9 after 2 cycles; y=0x80 -> p=1152 after 8 cycles.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-and-add unsigned multiplier, N x N -> 2N bits.
// One ripple_carry_adder forms each partial sum; valid/ready handshakes on
// both the operand and product sides.
// Optional build macro SEQ_MULTIPLIER_EARLY_EXIT_EN: finish as soon as the
// remaining multiplier bits are all zero (same product, shorter latency).

module ripple_carry_adder #(
   parameter int N = 32
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] carry;

   assign carry[0] = cin;

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_bit
         assign sum[i]       = x[i] ^ y[i] ^ carry[i];
         assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
      end
   endgenerate

   assign cout = carry[N];

endmodule

module seq_multiplier #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   x,
   input  logic [N-1:0]   y,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] p
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [N-1:0]    mcand;
   logic [N-1:0]    mcand_nxt;
   logic [N-1:0]    hi;
   logic [N-1:0]    hi_nxt;
   logic [N-1:0]    lo;
   logic [N-1:0]    lo_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [2*N-1:0]  p_nxt;

   // adder interface: partial product is mcand gated by the current multiplier bit
   logic [N-1:0]    addend;
   logic [N-1:0]    sum;
   logic            cout;
   logic [2*N-1:0]  step_val;

   assign addend   = lo[0] ? mcand : {N{1'b0}};
   // the carry-out is shifted into the top so the 2N-bit result never overflows
   assign step_val = {cout, sum, lo[N-1:1]};

   ripple_carry_adder #(.N(N)) u_adder (
      .x    (hi),
      .y    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
   // unprocessed multiplier bits occupy lo[N-1-cnt:0]
   logic [N-1:0]    remain_mask;
   logic            remain_zero;
   logic [CW-1:0]   exit_shift;
   logic [2*N-1:0]  exit_val;

   assign remain_mask = {N{1'b1}} >> cnt;
   assign remain_zero = ((lo & remain_mask) == {N{1'b0}});
   assign exit_shift  = CW'(N) - cnt;
   // each skipped iteration would add zero and shift right once
   assign exit_val    = {hi, lo} >> exit_shift;
`endif

   // handshake outputs decode the state register only
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // next-state, datapath and product-register updates
   always_comb begin
      state_nxt = state;
      mcand_nxt = mcand;
      hi_nxt    = hi;
      lo_nxt    = lo;
      cnt_nxt   = cnt;
      p_nxt     = p;
      case (state)
         IDLE: begin
            if (in_valid) begin
               mcand_nxt = x;
               hi_nxt    = {N{1'b0}};
               lo_nxt    = y;
               cnt_nxt   = {CW{1'b0}};
               state_nxt = BUSY;
            end else begin
               state_nxt = IDLE;
            end
         end
         BUSY: begin
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
            if (remain_zero) begin
               {hi_nxt, lo_nxt} = exit_val;
               cnt_nxt          = cnt + CNT_ONE;
               p_nxt            = exit_val;
               state_nxt        = DONE;
            end else begin
               {hi_nxt, lo_nxt} = step_val;
               cnt_nxt          = cnt + CNT_ONE;
               if (cnt == CNT_LAST) begin
                  p_nxt     = step_val;
                  state_nxt = DONE;
               end else begin
                  state_nxt = BUSY;
               end
            end
`else
            {hi_nxt, lo_nxt} = step_val;
            cnt_nxt          = cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
               p_nxt     = step_val;
               state_nxt = DONE;
            end else begin
               state_nxt = BUSY;
            end
`endif
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = DONE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // state and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         mcand <= {N{1'b0}};
         hi    <= {N{1'b0}};
         lo    <= {N{1'b0}};
         cnt   <= {CW{1'b0}};
         p     <= {(2*N){1'b0}};
      end else begin
         state <= state_nxt;
         mcand <= mcand_nxt;
         hi    <= hi_nxt;
         lo    <= lo_nxt;
         cnt   <= cnt_nxt;
         p     <= p_nxt;
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (N=8): the driver pushes expected
// products and latencies when operands are accepted; a negedge monitor
// checks every presented product, its latency and the handshake flags.
`timescale 1ns/1ps

module tb_seq_multiplier;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   x;
   logic [N-1:0]   y;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] p;

   seq_multiplier #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2*N-1:0] prod;
      int             lat;
      int             cap;
      bit             seen;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   bit   stream_mode = 1'b0;
   int   prev_cap = -1;
   int   prev_lat = 0;

   // reference latency from the position of y's most significant set bit
   function automatic int ref_latency(input logic [N-1:0] yy);
      int k;
      k = -1;
      for (int i = 0; i < N; i++) if (yy[i]) k = i;
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
      if (k < 0) return 1;
      if (k < N - 1) return k + 2;
      return N;
`else
      return (k < 0) ? N : N;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // monitor + scoreboard: compares outputs, tracks accepted operands
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         check("rst_in_ready", {63'd0, in_ready}, 64'd1);
         check("rst_out_valid", {63'd0, out_valid}, 64'd0);
         check("rst_p", {48'd0, p}, 64'd0);
      end else begin
         check("in_ready", {63'd0, in_ready}, (sb.size() == 0) ? 64'd1 : 64'd0);
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("spurious_out_valid", 64'd1, 64'd0);
            end else begin
               if (!sb[0].seen) begin
                  check("latency", 64'(cyc - sb[0].cap), 64'(sb[0].lat));
                  sb[0].seen = 1'b1;
               end
               check("p", {48'd0, p}, {48'd0, sb[0].prod});
               if (out_ready) void'(sb.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            exp_t e;
            logic [2*N-1:0] xa, ya;
            xa = {{N{1'b0}}, x};
            ya = {{N{1'b0}}, y};
            e.prod = xa * ya;
            e.lat  = ref_latency(y);
            e.cap  = cyc + 1;
            e.seen = 1'b0;
            if (stream_mode) begin
               if (prev_cap >= 0) check("ii", 64'(e.cap - prev_cap), 64'(prev_lat + 2));
               prev_cap = e.cap;
               prev_lat = e.lat;
            end
            sb.push_back(e);
         end
      end
   end

   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
      bit got;
      got = 1'b0;
      x = a;
      y = b;
      in_valid = 1'b1;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (in_ready && !rst) got = 1'b1;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout actual=no_accept required=accept t=%0t", $time);
      end
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic drain();
      bit empty;
      empty = 1'b0;
      for (int t = 0; t < 300 && !empty; t++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) empty = 1'b1;
      end
      if (!empty) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      bit seen_valid;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x         = '0;
      y         = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // basic product and return to idle
      issue(8'd3, 8'd5, 1'b0);
      drain();
      check("p_hold_idle", {48'd0, p}, 64'd15);

      // all-ones operands exercise every carry-out
      issue(8'd255, 8'd255, 1'b0);
      drain();
      check("p_max", {48'd0, p}, 64'hFE01);

      // stalled consumer: product must hold while out_ready is low
      out_ready = 1'b0;
      issue(8'd200, 8'd0, 1'b0);
      seen_valid = 1'b0;
      for (int t = 0; t < 50 && !seen_valid; t++) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      check("stall_out_valid", {63'd0, seen_valid}, 64'd1);
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      // reset during the 4th busy cycle aborts the operation
      issue(8'd7, 8'd9, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      issue(8'd6, 8'd7, 1'b0);
      drain();
      check("p_after_abort", {48'd0, p}, 64'd42);

      // short-multiplier cases (latency depends on build option)
      issue(8'd9, 8'd0, 1'b0);
      drain();
      issue(8'd9, 8'd1, 1'b0);
      drain();
      issue(8'd9, 8'h80, 1'b0);
      drain();
      check("p_9x128", {48'd0, p}, 64'd1152);

      // back-to-back stream with in_valid held high
      stream_mode = 1'b1;
      prev_cap = -1;
      for (int i = 0; i < 100; i++) begin
         issue(8'($urandom), 8'($urandom), (i != 99));
      end
      drain();
      stream_mode = 1'b0;

      // random consumer back-pressure
      for (int i = 0; i < 20; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         issue(8'($urandom), 8'($urandom), 1'b0);
         for (int t = 0; t < 200 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
         end
         out_ready = 1'b1;
         drain();
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
